// File: rtl/mmio_pkg.sv
// mmio_pkg: shared definitions for the memory-mapped timer and its bus neighbours.
// Holds the register offsets inside the 256-byte window, the CTRL bit layout, the
// access-size encodings carried on the CPU `sel` lines, the default window base, and
// small helpers for register decode and byte-lane merging.
package mmio_pkg;

    // Default window base; the low byte must stay zero.
    localparam logic [31:0] DefaultBaseAddr = 32'hFFFF_0000;

    // Byte offsets of the timer registers inside the window.
    localparam logic [7:0] OffCtrl    = 8'h00;
    localparam logic [7:0] OffCount   = 8'h04;
    localparam logic [7:0] OffCompare = 8'h08;
    localparam logic [7:0] OffStatus  = 8'h0C;

    // CTRL bit positions.
    localparam int unsigned CtrlEnBit         = 0;
    localparam int unsigned CtrlAutoReloadBit = 1;
    localparam int unsigned CtrlIrqEnBit      = 2;
    localparam int unsigned CtrlPrescaleLsb   = 16;
    localparam int unsigned CtrlPrescaleMsb   = 31;

    // STATUS bit positions.
    localparam int unsigned StatusMatchBit = 0;

    // Bits of CTRL that hold state; everything else reads back as zero.
    localparam logic [31:0] CtrlWritableMask = 32'hFFFF_0007;

    // Access size as driven on `sel`.
    typedef enum logic [1:0] {
        SizeWord = 2'b00,
        SizeHalf = 2'b01,
        SizeByte = 2'b10,
        SizeNone = 2'b11
    } size_sel_e;

    // Decoded register target of an in-window access.
    typedef enum logic [2:0] {
        RegCtrl,
        RegCount,
        RegCompare,
        RegStatus,
        RegNone
    } reg_sel_e;

    // Map a word index (Addr[7:2]) to the register it selects.
    function automatic reg_sel_e decode_reg(input logic [5:0] word_idx);
        if (word_idx == OffCtrl[7:2]) begin
            return RegCtrl;
        end
        if (word_idx == OffCount[7:2]) begin
            return RegCount;
        end
        if (word_idx == OffCompare[7:2]) begin
            return RegCompare;
        end
        if (word_idx == OffStatus[7:2]) begin
            return RegStatus;
        end
        return RegNone;
    endfunction

    // Widen a 4-bit byte enable to a 32-bit bit mask.
    function automatic logic [31:0] expand_byte_en(input logic [3:0] byte_en);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{byte_en[i]}};
        end
        return mask;
    endfunction

    // Replace the enabled byte lanes of old_val with those of new_val.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  byte_en);
        logic [31:0] mask;
        mask = expand_byte_en(byte_en);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/mmio_lane_mask.sv
// mmio_lane_mask: combinational byte-enable decoder shared by the timer and the RAM.
// Turns the CPU access size and the low two address bits into the set of byte lanes
// a store touches. Sub-word stores are expected to be naturally aligned.
//
// Ports:
//   sel_i      access size (word / halfword / byte / reserved)
//   addr_lo_i  Addr[1:0] of the access
//   byte_en_o  one bit per byte lane, lane 0 = bits [7:0]
module mmio_lane_mask
    import mmio_pkg::*;
(
    input  logic [1:0] sel_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] byte_en_o
);

    always_comb begin
        byte_en_o = 4'b0000;
        unique case (size_sel_e'(sel_i))
            SizeWord: byte_en_o = 4'b1111;
            // Halfword lane pair is picked by Addr[1]; Addr[0] is ignored.
            SizeHalf: byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            SizeByte: byte_en_o = 4'b0001 << addr_lo_i;
            SizeNone: byte_en_o = 4'b0000;
            default:  byte_en_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped timer/compare responder on the Multi_Cyclic_MIPS memory bus.
// Shares address, write data, write strobe and size select with the RAM and answers
// accesses inside a 256-byte window. Provides a prescaled 32-bit up-counter, a compare
// register, a sticky match flag and an interrupt line.
//
// System integration: RAM write enable is MEM_WS & ~Hit, and the CPU read-data input is
// Hit ? timer Output_Data : RAM Output_Data.
//
// Register map (Addr[7:2]):
//   0x00 CTRL    bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[31:16] PRESCALE
//   0x04 COUNT   read/write
//   0x08 COMPARE read/write
//   0x0C STATUS  bit0 MATCH, write 1 to clear
//   others       read 0, writes ignored
//
// Ports:
//   CLK          single rising-edge clock
//   RST          synchronous active-high reset
//   Addr         CPU byte address
//   Data         CPU write data
//   W_EN         CPU write strobe
//   sel          access size (00 word, 01 half, 10 byte, 11 none)
//   Output_Data  combinational read data, zero when not hit
//   Hit          address falls inside the window
//   IRQ          MATCH & IRQ_EN
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int unsigned                ADDRESS_WIDTH = 32,
    parameter int unsigned                DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDR     = ADDRESS_WIDTH'(DefaultBaseAddr)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0]    Data,
    input  logic                     W_EN,
    input  logic [1:0]               sel,
    output logic [DATA_WIDTH-1:0]    Output_Data,
    output logic                     Hit,
    output logic                     IRQ
);

    // Architectural state.
    logic [31:0] ctrl_q,    ctrl_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic        match_q,   match_d;
    logic [15:0] pcnt_q,    pcnt_d;

    // Bus decode.
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  byte_en;
    reg_sel_e    reg_sel;
    logic        wr_any;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_compare;
    logic        status_clr;

    // Counter control.
    logic        en;
    logic        auto_reload;
    logic [15:0] prescale;
    logic        tick;
    logic        match_set;

    assign wdata   = Data[31:0];
    assign Hit     = (Addr[ADDRESS_WIDTH-1:8] == BASE_ADDR[ADDRESS_WIDTH-1:8]);
    assign reg_sel = decode_reg(Addr[7:2]);

    mmio_lane_mask u_lane_mask (
        .sel_i     (sel),
        .addr_lo_i (Addr[1:0]),
        .byte_en_o (byte_en)
    );

    // A write with no enabled lane (reserved size) is no write at all, so it must not
    // clear the prescaler either.
    assign wr_any     = W_EN & Hit & (|byte_en);
    assign wr_ctrl    = wr_any & (reg_sel == RegCtrl);
    assign wr_count   = wr_any & (reg_sel == RegCount);
    assign wr_compare = wr_any & (reg_sel == RegCompare);
    // Only lane 0 carries the clear bit.
    assign status_clr = wr_any & (reg_sel == RegStatus) & byte_en[0] & wdata[StatusMatchBit];

    assign en          = ctrl_q[CtrlEnBit];
    assign auto_reload = ctrl_q[CtrlAutoReloadBit];
    assign prescale    = ctrl_q[CtrlPrescaleMsb:CtrlPrescaleLsb];

    // Tick and match use the pre-edge register values, so a same-cycle write to CTRL
    // or COMPARE only affects later ticks.
    assign tick      = en & (pcnt_q == prescale);
    assign match_set = tick & (count_q == compare_q);

    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        pcnt_d    = pcnt_q;

        // Prescaler: a CTRL write restarts it; otherwise it free-runs while enabled.
        if (wr_ctrl) begin
            pcnt_d = 16'h0000;
        end else if (tick) begin
            pcnt_d = 16'h0000;
        end else if (en) begin
            pcnt_d = pcnt_q + 16'h0001;
        end

        // Counter: a CPU write overrides the tick update; unwritten lanes keep the
        // pre-increment value.
        if (tick) begin
            if (match_set && auto_reload) begin
                count_d = 32'h0000_0000;
            end else begin
                count_d = count_q + 32'h0000_0001;
            end
        end
        if (wr_count) begin
            count_d = merge_lanes(count_q, wdata, byte_en);
        end

        if (wr_ctrl) begin
            ctrl_d = merge_lanes(ctrl_q, wdata, byte_en) & CtrlWritableMask;
        end

        if (wr_compare) begin
            compare_d = merge_lanes(compare_q, wdata, byte_en);
        end

        // Set beats clear when both land in the same cycle.
        if (match_set) begin
            match_d = 1'b1;
        end else if (status_clr) begin
            match_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ctrl_q    <= 32'h0000_0000;
            count_q   <= 32'h0000_0000;
            compare_q <= 32'h0000_0000;
            match_q   <= 1'b0;
            pcnt_q    <= 16'h0000;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            pcnt_q    <= pcnt_d;
        end
    end

    // Read path returns the whole aligned word; lane extraction happens in the CPU.
    always_comb begin
        rdata = 32'h0000_0000;
        if (Hit) begin
            unique case (reg_sel)
                RegCtrl:    rdata = ctrl_q;
                RegCount:   rdata = count_q;
                RegCompare: rdata = compare_q;
                RegStatus:  rdata = {31'h0000_0000, match_q};
                RegNone:    rdata = 32'h0000_0000;
                default:    rdata = 32'h0000_0000;
            endcase
        end
    end

    assign Output_Data = DATA_WIDTH'(rdata);
    assign IRQ         = match_q & ctrl_q[CtrlIrqEnBit];

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed scenarios followed by randomized bus
// traffic, all compared against a behavioural model of the register file.
module tb_mmio_timer;

    localparam logic [31:0] A_CTRL    = 32'hFFFF_0000;
    localparam logic [31:0] A_COUNT   = 32'hFFFF_0004;
    localparam logic [31:0] A_COMPARE = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [1:0]  sel;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    always #5 clk = ~clk;

    mmio_timer #(
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (32'hFFFF_0000)
    ) dut (
        .CLK         (clk),
        .RST         (rst),
        .Addr        (addr),
        .Data        (wdata),
        .W_EN        (wen),
        .sel         (sel),
        .Output_Data (rdata),
        .Hit         (hit),
        .IRQ         (irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_ctrl, m_count, m_compare;
    logic        m_match;
    int unsigned m_pcnt;
    bit          m_valid = 1'b0;

    function automatic logic model_hit(input logic [31:0] a);
        return a[31:8] == 24'hFFFF00;
    endfunction

    // Bits of the 32-bit word that a store of size s at low address lo writes.
    function automatic logic [31:0] store_bits(input logic [1:0] s, input logic [1:0] lo);
        case (s)
            2'b00:   return 32'hFFFF_FFFF;
            2'b01:   return lo[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            2'b10:   return 32'h0000_00FF << (8 * lo);
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!model_hit(a)) return 32'h0;
        case (a[7:0] & 8'hFC)
            8'h00:   return m_ctrl;
            8'h04:   return m_count;
            8'h08:   return m_compare;
            8'h0C:   return {31'h0, m_match};
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently on the bus.
    task automatic model_edge();
        logic [31:0] m;
        logic [31:0] old_count;
        logic [7:0]  off;
        bit          ticking;
        bit          matching;
        if (rst) begin
            m_ctrl = 0; m_count = 0; m_compare = 0; m_match = 0; m_pcnt = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        m         = (wen && model_hit(addr)) ? store_bits(sel, addr[1:0]) : 32'h0;
        off       = addr[7:0] & 8'hFC;
        old_count = m_count;
        ticking   = m_ctrl[0] && (m_pcnt == int'(m_ctrl[31:16]));
        matching  = ticking && (m_count == m_compare);

        if (ticking) m_count = (matching && m_ctrl[1]) ? 32'h0 : m_count + 1;
        if (off == 8'h04 && m != 0) m_count = (old_count & ~m) | (wdata & m);

        if (off == 8'h00 && m != 0) m_pcnt = 0;
        else if (ticking)           m_pcnt = 0;
        else if (m_ctrl[0])         m_pcnt = m_pcnt + 1;

        if (off == 8'h00 && m != 0) m_ctrl = ((m_ctrl & ~m) | (wdata & m)) & 32'hFFFF_0007;
        if (off == 8'h08 && m != 0) m_compare = (m_compare & ~m) | (wdata & m);

        if (matching) m_match = 1'b1;
        else if (off == 8'h0C && m[0] && wdata[0]) m_match = 1'b0;
    endtask

    // ---------------- bus driving ----------------
    task automatic apply(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic [1:0] s);
        @(negedge clk);
        rst = r; addr = a; wdata = d; wen = w; sel = s;
        #1;
        if (m_valid) begin
            check("hit",   32'(hit),   32'(model_hit(a)));
            check("rdata", rdata,      model_read(a));
            check("irq",   32'(irq),   32'(m_match & m_ctrl[2]));
        end
    endtask

    task automatic commit();
        @(posedge clk);
        model_edge();
    endtask

    task automatic op(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic w, input logic [1:0] s);
        apply(r, a, d, w, s);
        commit();
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        op(1'b0, a, d, 1'b1, 2'b00);
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] a;
        logic [31:0] d;
        int          r;

        rst = 1'b1; addr = 0; wdata = 0; wen = 0; sel = 0;

        // 1. Reset held for two cycles, then every register reads zero.
        op(1'b1, 32'h0, 32'h0, 1'b0, 2'b00);
        op(1'b1, 32'h0, 32'h0, 1'b0, 2'b00);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, A_CTRL + 32'(4 * i), 32'h0, 1'b0, 2'b00);
            check("reset_read", rdata, 32'h0);
            check("reset_irq", 32'(irq), 32'h0);
            commit();
        end

        // 2. Auto-reload match with PRESCALE=0.
        wr32(A_COMPARE, 32'd3);
        wr32(A_CTRL, 32'h0000_0007);
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
            check("ar_count", rdata, (i == 4) ? 32'd0 : 32'(i));
            check("ar_irq", 32'(irq), (i == 4) ? 32'd1 : 32'd0);
            commit();
        end
        apply(1'b0, A_STATUS, 32'h0, 1'b0, 2'b00);
        check("ar_match", rdata, 32'd1);
        commit();
        wr32(A_CTRL, 32'h0);
        wr32(A_STATUS, 32'h1);

        // 3. Prescale of 2 with wrap through zero.
        wr32(A_COUNT, 32'hFFFF_FFFE);
        wr32(A_COMPARE, 32'd5);
        wr32(A_CTRL, 32'h0002_0001);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
            check("ps_count", rdata, 32'hFFFF_FFFE + 32'(i / 3));
            commit();
        end
        apply(1'b0, A_STATUS, 32'h0, 1'b0, 2'b00);
        check("ps_nomatch", rdata, 32'd0);
        commit();
        wr32(A_CTRL, 32'h0);

        // 4. Sub-word writes with the counter stopped.
        wr32(A_COUNT, 32'h1122_3344);
        op(1'b0, 32'hFFFF_0005, 32'hAAAA_AAAA, 1'b1, 2'b10);
        apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
        check("sw_byte", rdata, 32'h1122_AA44);
        commit();
        op(1'b0, 32'hFFFF_0006, 32'hBEEF_BEEF, 1'b1, 2'b01);
        apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
        check("sw_half", rdata, 32'hBEEF_AA44);
        commit();
        op(1'b0, A_COUNT, 32'h0, 1'b1, 2'b11);
        apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
        check("sw_none", rdata, 32'hBEEF_AA44);
        commit();

        // 5. Simultaneous events with a tick every cycle.
        wr32(A_COMPARE, 32'h12);
        wr32(A_CTRL, 32'h0000_0007);
        wr32(A_COUNT, 32'h10);
        apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
        check("sim_cnt_wr", rdata, 32'h10);
        commit();
        op(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
        wr32(A_STATUS, 32'h1);  // lands on the matching tick
        apply(1'b0, A_STATUS, 32'h0, 1'b0, 2'b00);
        check("sim_set_wins", rdata, 32'd1);
        check("sim_irq_hi", 32'(irq), 32'd1);
        commit();
        wr32(A_STATUS, 32'h1);
        apply(1'b0, A_STATUS, 32'h0, 1'b0, 2'b00);
        check("sim_clr", rdata, 32'd0);
        check("sim_irq_lo", 32'(irq), 32'd0);
        commit();
        wr32(A_CTRL, 32'h0);

        // 6. Decode outside and inside the window.
        saved = m_count;
        apply(1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 1'b1, 2'b00);
        check("dec_miss_hit", 32'(hit), 32'd0);
        check("dec_miss_rd", rdata, 32'd0);
        commit();
        apply(1'b0, A_COUNT, 32'h0, 1'b0, 2'b00);
        check("dec_unchanged", rdata, saved);
        commit();
        apply(1'b0, 32'hFFFF_0020, 32'h0, 1'b0, 2'b00);
        check("dec_hole_rd", rdata, 32'd0);
        check("dec_hole_hit", 32'(hit), 32'd1);
        commit();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 85) begin
                a = 32'hFFFF_0000 | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
            end else if (r < 92) begin
                a = 32'hFFFF_0000 | ($urandom & 32'hFF);
            end else begin
                a = $urandom;
            end
            d = $urandom;
            if ((a[7:0] & 8'hFC) == 8'h00) begin
                d = (d & 32'h0000_FFFF) | (32'($urandom_range(0, 3)) << 16);
            end else if (((a[7:0] & 8'hFC) == 8'h04 || (a[7:0] & 8'hFC) == 8'h08) &&
                         $urandom_range(0, 3) != 0) begin
                d = 32'($urandom_range(0, 24));
            end
            op(($urandom_range(0, 299) == 0), a, d, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer/compare responder for the Multi_Cyclic_MIPS memory bus. It sits beside the RAM on the same address, write-data, write-enable and size-select signals, and answers accesses that fall inside its 256-byte window. It provides a prescaled 32-bit up-counter, a compare register, a sticky match flag and an interrupt line. The top level muxes the CPU read-data input between RAM and this block using `Hit`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: window base; bits [7:0] must be zero.
- `ADDRESS_WIDTH`, default 32: bus address width.
- `DATA_WIDTH`, default 32: bus data width. Register layout assumes 32.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `Addr`  in  ADDRESS_WIDTH: byte address from the CPU.
- `Data`  in  DATA_WIDTH: write data (CPU Reg2_Out).
- `W_EN`  in  1: write strobe (CPU MEM_WS).
- `sel`  in  2: access size (CPU RAM_SEL). 00 = word, 01 = halfword, 10 = byte, 11 = reserved.
- `Output_Data`  out  DATA_WIDTH: read data. Combinational from `Addr` and the registers.
- `Hit`  out  1: `Addr[31:8] == BASE_ADDR[31:8]`.
- `IRQ`  out  1: `STATUS.MATCH & CTRL.IRQ_EN`.

## Operation
Register map, selected by `Addr[7:2]`:
- 0x00 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[31:16] PRESCALE. All other bits read 0.
- 0x04 COUNT: read/write.
- 0x08 COMPARE: read/write.
- 0x0C STATUS: bit0 MATCH. Writing 1 to bit0 clears MATCH; writing 0 has no effect.
- Offsets 0x10–0xFC: read 0, writes ignored.

Reads:
- When `Hit=1`, `Output_Data` is the full aligned 32-bit register, regardless of `sel` or `Addr[1:0]`. Lane extraction is the CPU load path's job, as for RAM.
- When `Hit=0`, `Output_Data` is 0.

Writes:
- A write takes effect on the rising edge when `W_EN & Hit`.
- `sel=00`: all 4 byte lanes are written.
- `sel=01`: lanes {1,0} are written if `Addr[1]=0`, lanes {3,2} if `Addr[1]=1`.
- `sel=10`: the single lane `Addr[1:0]` is written.
- `sel=11`: no write.
- For STATUS, only lane 0 matters for the clear.

Counting:
- The prescaler PCNT (16 bit, internal) runs only when EN=1.
- A tick occurs when EN=1 and PCNT==PRESCALE. On a tick PCNT returns to 0; otherwise PCNT increments.
- On a tick, if COUNT==COMPARE: MATCH is set, and COUNT becomes 0 when AUTO_RELOAD=1, else COUNT+1.
- On a tick with no match: COUNT becomes COUNT+1, wrapping 0xFFFF_FFFF→0.
- Match period with AUTO_RELOAD is (COMPARE+1)·(PRESCALE+1) cycles.

Simultaneous events:
- A CPU write to COUNT in a tick cycle: the written value wins and no increment occurs. Unwritten lanes keep the old value.
- A CPU write to CTRL clears PCNT to 0 in the same edge.
- A STATUS clear and a match set in the same cycle: the set wins, so MATCH stays 1.
- A write to COMPARE in a tick cycle: the match check uses the old COMPARE.
- EN=0: PCNT and COUNT hold their values.

## Timing
- Reset (`RST=1` at an edge) clears CTRL, COUNT, COMPARE, MATCH and PCNT to 0. As a result `IRQ=0` and `Output_Data=0` for every hit register.
- Reset overrides any write or tick in the same cycle.
- Reset mid-count discards all state; there is no resumption.
- Read latency is 0 cycles (combinational).
- Write latency is 1 edge: the value is readable in the cycle after the write edge.
- `IRQ` rises in the cycle after the matching tick edge. It stays high until MATCH is cleared or IRQ_EN is cleared.

## Structure
- A shared package `mmio_pkg` holds:
  - register offsets: CTRL 0x00, COUNT 0x04, COMPARE 0x08, STATUS 0x0C;
  - CTRL bit positions;
  - the `sel` size encodings;
  - the default `BASE_ADDR`.
- One sub-module, `mmio_lane_mask`: a combinational decoder from (`sel`, `Addr[1:0]`) to a 4-bit byte-enable. RAM reuses it.
- Top integration:
  - the RAM write enable is `MEM_WS & ~Hit`;
  - the CPU `DATA` input is `Hit ? timer.Output_Data : RAM.Output_Data`.

## Test plan
1. **Reset:** hold `RST` for 2 cycles, then read 0xFFFF_0000–0x0C. Expect all reads 0 and `IRQ=0`.
2. **Auto-reload match:**
   - write COMPARE=3, then CTRL=0x0000_0007 (PRESCALE=0);
   - expect COUNT to read 0, 1, 2, 3, 0 on consecutive cycles;
   - expect MATCH=1 and `IRQ=1` one cycle after the COUNT=3 tick.
3. **Prescale and wrap:**
   - write COUNT=0xFFFF_FFFE, COMPARE=5, CTRL=0x0002_0001;
   - expect COUNT to step every 3 cycles: 0xFFFF_FFFF, then 0, then 1;
   - expect no match until COUNT passes 5.
4. **Sub-word writes:**
   - COUNT=0x1122_3344 with EN=0; byte write 0xAA at 0xFFFF_0005 gives 0x1122_AA44;
   - halfword write 0xBEEF at 0xFFFF_0006 gives 0xBEEF_AA44;
   - `sel=11` with data 0 leaves COUNT at 0xBEEF_AA44.
5. **Simultaneous events:**
   - COUNT write of 0x10 in a tick cycle: next read is 0x10;
   - STATUS write 0x1 in a match cycle: MATCH stays 1;
   - STATUS write 0x1 in a later non-match cycle: MATCH=0 and `IRQ` falls.
6. **Decode:**
   - word write to 0x0000_0004 leaves `Hit=0` and timer registers unchanged;
   - a read of 0xFFFF_0020 returns 0 with `Hit=1`.
